// File: rtl/trng_conditioner_sequencer.sv
// rtl/trng_conditioner_sequencer.sv - TRNG seed collection, hash sequencing and byte output
// Hashed mode: gather a seed block, run the hash core, stream the digest MSB byte first; raw mode packs bits into bytes.
module trng_conditioner_sequencer #(
    parameter int SEED_BITS   = 448,
    parameter int DIGEST_BITS = 256
) (
    input  logic                   TRNG_Clock,
    input  logic                   TRNG_Enable,
    input  logic                   ctrl_mode,
    input  logic                   bit_valid,
    input  logic                   bit_in,
    input  logic                   rct_fail,
    output logic [SEED_BITS-1:0]   seed,
    output logic                   hash_start,
    input  logic                   hash_done,
    input  logic [DIGEST_BITS-1:0] digest,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   hash_rdy,
    output logic                   failure,
    output logic                   overrun
);
    localparam int CW     = $clog2(SEED_BITS + 1);
    localparam int NBYTES = DIGEST_BITS / 8;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] C_LAST_SEED = CW'(SEED_BITS - 1);
    localparam logic [CW-1:0] C_LAST_BIT  = CW'(7);
    localparam logic [IW-1:0] C_LAST_IDX  = IW'(NBYTES - 1);

    typedef enum logic [1:0] {S_COLLECT, S_START, S_HASH_WAIT, S_SEND} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CW-1:0]          r_count;
    logic [IW-1:0]          r_idx;
    logic [SEED_BITS-1:0]   r_seed;
    logic [DIGEST_BITS-1:0] r_buf;
    logic [7:0]             r_tx_byte;
    logic                   r_tx_valid;
    logic                   r_mode;
    logic                   r_hash_rdy;
    logic                   r_failure;
    logic                   r_overrun;

    logic                   w_collect;
    logic                   w_mode;
    logic                   w_accept;
    logic                   w_reject;
    logic                   w_byte_done;
    logic                   w_seed_done;
    logic                   w_send_hs;
    logic                   w_last_byte;
    logic [SEED_BITS-1:0]   w_seed_shift;

    // Mode may only change at an idle point: collecting, nothing partial, nothing pending.
    assign w_collect    = (r_state == S_COLLECT);
    assign w_mode       = (w_collect && (r_count == '0) && !r_tx_valid) ? ctrl_mode : r_mode;
    assign w_accept     = w_collect && bit_valid && !rct_fail;
    assign w_reject     = w_collect && bit_valid && rct_fail;
    assign w_byte_done  = w_accept && w_mode && (r_count == C_LAST_BIT);
    assign w_seed_done  = w_accept && !w_mode && (r_count == C_LAST_SEED);
    assign w_send_hs    = (r_state == S_SEND) && tx_ready;
    assign w_last_byte  = (r_idx == C_LAST_IDX);
    assign w_seed_shift = {r_seed[SEED_BITS-2:0], bit_in};

    assign seed     = r_seed;
    assign hash_rdy = r_hash_rdy;
    assign failure  = r_failure;
    assign overrun  = r_overrun;

    always_ff @(posedge TRNG_Clock or posedge TRNG_Enable) begin
        if (TRNG_Enable) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        hash_start = 1'b0;
        tx_valid   = r_tx_valid;
        tx_data    = r_tx_byte;
        case (r_state)
            S_COLLECT: begin
                if (w_seed_done) w_next = S_START;
            end
            S_START: begin
                hash_start = 1'b1;
                w_next     = S_HASH_WAIT;
            end
            S_HASH_WAIT: begin
                if (hash_done) w_next = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = r_buf[DIGEST_BITS-1 -: 8];
                if (tx_ready && w_last_byte) w_next = S_COLLECT;
            end
            default: w_next = S_COLLECT;
        endcase
    end

    always_ff @(posedge TRNG_Clock or posedge TRNG_Enable) begin
        if (TRNG_Enable) begin
            r_count    <= '0;
            r_idx      <= '0;
            r_seed     <= '0;
            r_buf      <= '0;
            r_tx_byte  <= '0;
            r_tx_valid <= 1'b0;
            r_mode     <= 1'b0;
            r_hash_rdy <= 1'b0;
            r_failure  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_mode     <= w_mode;
            r_failure  <= w_reject;
            r_hash_rdy <= 1'b0;

            if (w_accept) r_seed <= w_seed_shift;

            if (w_reject || w_byte_done || w_seed_done) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= r_count + 1'b1;
            end

            // A new raw byte may replace the pending one only in the cycle it is taken.
            if (w_byte_done) begin
                if (!r_tx_valid || tx_ready) begin
                    r_tx_byte  <= w_seed_shift[7:0];
                    r_tx_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_tx_valid && tx_ready) begin
                r_tx_valid <= 1'b0;
            end

            if ((r_state == S_HASH_WAIT) && hash_done) begin
                r_buf      <= digest;
                r_idx      <= '0;
                r_hash_rdy <= 1'b1;
            end else if (w_send_hs) begin
                r_buf <= r_buf << 8;
                if (!w_last_byte) r_idx <= r_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_trng_conditioner_sequencer.sv
// tb/tb_trng_conditioner_sequencer.sv - randomized self-checking bench with a queue-based reference model
module tb_trng_conditioner_sequencer;
    localparam int SB = 448;
    localparam int DB = 256;
    localparam int NB = DB / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ctrl_mode = 1'b0;
    logic          bit_valid = 1'b0;
    logic          bit_in = 1'b0;
    logic          rct_fail = 1'b0;
    logic          hash_done = 1'b0;
    logic          tx_ready = 1'b0;
    logic [DB-1:0] digest = '0;
    logic [SB-1:0] seed;
    logic          hash_start;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          hash_rdy;
    logic          failure;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    trng_conditioner_sequencer #(.SEED_BITS(SB), .DIGEST_BITS(DB)) dut (
        .TRNG_Clock (clk),
        .TRNG_Enable(rst),
        .ctrl_mode  (ctrl_mode),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .rct_fail   (rct_fail),
        .seed       (seed),
        .hash_start (hash_start),
        .hash_done  (hash_done),
        .digest     (digest),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .hash_rdy   (hash_rdy),
        .failure    (failure),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [SB-1:0] act, input logic [SB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 collect, 1 start pulse, 2 waiting for hash, 3 sending digest
    int         m_phase;
    int         m_cnt;
    bit         m_mode, m_txv, m_fail, m_rdy, m_ovr;
    bit [7:0]   m_txd;
    bit [SB-1:0] m_seed;
    bit         m_hist[$];
    bit [7:0]   m_q[$];

    always @(posedge clk or posedge rst) begin
        bit       nb;
        bit [7:0] byt;
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_mode = 0; m_txv = 0; m_fail = 0; m_rdy = 0; m_ovr = 0;
            m_txd = 0; m_seed = '0;
            m_hist.delete();
            m_q.delete();
        end else begin
            m_fail = 0;
            m_rdy  = 0;
            nb     = 0;
            byt    = 0;
            case (m_phase)
                0: begin
                    if (m_cnt == 0 && !m_txv) m_mode = ctrl_mode;
                    if (bit_valid && rct_fail) begin
                        m_cnt  = 0;
                        m_fail = 1;
                    end else if (bit_valid) begin
                        m_hist.push_back(bit_in);
                        if (m_hist.size() > SB) void'(m_hist.pop_front());
                        m_cnt++;
                        if (m_mode && m_cnt == 8) begin
                            for (int i = 0; i < 8; i++) byt[i] = m_hist[m_hist.size() - 1 - i];
                            nb    = 1;
                            m_cnt = 0;
                        end else if (!m_mode && m_cnt == SB) begin
                            for (int i = 0; i < SB; i++) m_seed[i] = m_hist[m_hist.size() - 1 - i];
                            m_cnt   = 0;
                            m_phase = 1;
                        end
                    end
                    if (nb) begin
                        if (!m_txv || tx_ready) begin
                            m_txd = byt;
                            m_txv = 1;
                        end else begin
                            m_ovr = 1;
                        end
                    end else if (m_txv && tx_ready) begin
                        m_txv = 0;
                    end
                end
                1: m_phase = 2;
                2: begin
                    if (hash_done) begin
                        for (int k = 0; k < NB; k++) m_q.push_back(digest[DB-1-8*k -: 8]);
                        m_rdy   = 1;
                        m_phase = 3;
                    end
                end
                default: begin
                    if (tx_ready) begin
                        void'(m_q.pop_front());
                        if (m_q.size() == 0) m_phase = 0;
                    end
                end
            endcase
        end
    end

    int       n_start = 0;
    int       n_rdy = 0;
    bit [1:0] start_seed_lo = 2'b00;
    bit [7:0] rx[$];

    always @(negedge clk) begin
        bit ev;
        ev = m_txv || (m_phase == 3);
        chk("hash_start", hash_start, m_phase == 1);
        chk("tx_valid", tx_valid, ev);
        if (ev) chk("tx_data", tx_data, (m_phase == 3) ? m_q[0] : m_txd);
        if (m_phase == 1 || m_phase == 2) chk("seed", seed, m_seed);
        chk("hash_rdy", hash_rdy, m_rdy);
        chk("failure", failure, m_fail);
        chk("overrun", overrun, m_ovr);
        if (hash_start) begin
            n_start++;
            start_seed_lo = seed[1:0];
        end
        if (hash_rdy) n_rdy++;
        if (tx_valid && tx_ready) rx.push_back(tx_data);
    end

    // Hash core stand-in: completes a fixed number of cycles after the start pulse
    int hc_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            hc_cnt    = 0;
            hash_done = 1'b0;
        end else begin
            hash_done = 1'b0;
            if (hc_cnt > 0) begin
                hc_cnt--;
                if (hc_cnt == 0) hash_done = 1'b1;
            end else if (hash_start) begin
                hc_cnt = 20;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put_bit(input bit b, input bit f);
        bit_valid = 1'b1;
        bit_in    = b;
        rct_fail  = f;
        cyc();
        bit_valid = 1'b0;
        rct_fail  = 1'($urandom_range(0, 1));
        bit_in    = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) cyc();
        rct_fail  = 1'b0;
    endtask

    task automatic wait_phase(input int target, input int budget, input string name);
        int n = 0;
        while (m_phase != target && n < budget) begin
            cyc();
            n++;
        end
        checks++;
        if (m_phase != target) begin
            errors++;
            $display("FAIL %s: timed out in phase %0d, required %0d", name, m_phase, target);
        end
    endtask

    task automatic rand_digest();
        for (int w = 0; w < DB / 32; w++) digest[32*w +: 32] = $urandom();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int       b_start, b_rdy, b_rx;
        bit [7:0] a_byte, b_byte;
        bit [7:0] raw_pat;

        for (int k = 0; k < NB; k++) digest[DB-1-8*k -: 8] = 8'(k);
        repeat (3) cyc();
        chk("reset tx_valid", tx_valid, 0);
        chk("reset tx_data", tx_data, 0);
        chk("reset hash_start", hash_start, 0);
        chk("reset seed", seed, 0);
        chk("reset overrun", overrun, 0);
        chk("reset failure", failure, 0);
        rst = 1'b0;
        tx_ready = 1'b1;

        // Hashed happy path, alternating pattern starting with 1
        b_start = n_start; b_rdy = n_rdy; b_rx = rx.size();
        for (int i = 0; i < SB; i++) put_bit((i % 2) == 0, 1'b0);
        wait_phase(0, 300, "happy path return");
        chk("happy start pulses", n_start - b_start, 1);
        chk("happy seed lsbs", start_seed_lo, 2'b10);
        chk("happy hash_rdy pulses", n_rdy - b_rdy, 1);
        chk("happy byte count", rx.size() - b_rx, NB);
        for (int k = 0; k < NB; k++) chk("happy byte order", rx[b_rx + k], 8'(k));

        // RCT reject resets the block, then a stalled and toggling send
        rand_digest();
        b_start = n_start;
        for (int i = 0; i < 100; i++) put_bit(1'($urandom_range(0, 1)), 1'b0);
        bit_valid = 1'b1; rct_fail = 1'b1;
        cyc();
        bit_valid = 1'b0; rct_fail = 1'b0;
        chk("reject failure pulse", failure, 1);
        cyc();
        chk("reject failure single", failure, 0);
        for (int i = 0; i < SB - 1; i++) put_bit(1'($urandom_range(0, 1)), 1'b0);
        repeat (3) cyc();
        chk("no start at 448 total", n_start - b_start, 0);
        tx_ready = 1'b0;
        b_rx = rx.size();
        put_bit(1'($urandom_range(0, 1)), 1'b0);
        wait_phase(3, 100, "reject block send");
        chk("reject block start", n_start - b_start, 1);
        for (int n = 0; n < 50; n++) begin
            chk("stall tx_valid", tx_valid, 1);
            chk("stall tx_data", tx_data, digest[DB-1 -: 8]);
            cyc();
        end
        for (int n = 0; n < 400 && m_phase != 0; n++) begin
            tx_ready = ~tx_ready;
            cyc();
        end
        chk("backpressure handshakes", rx.size() - b_rx, NB);
        for (int k = 0; k < NB; k++) chk("backpressure byte", rx[b_rx + k], digest[DB-1-8*k -: 8]);
        tx_ready = 1'b1;

        // Mode switch during HASH_WAIT only takes effect after the digest is out
        rand_digest();
        b_rx = rx.size();
        for (int i = 0; i < SB; i++) put_bit(1'($urandom_range(0, 1)), 1'b0);
        wait_phase(2, 20, "mode switch wait");
        ctrl_mode = 1'b1;
        wait_phase(0, 300, "mode switch send");
        chk("mode switch digest bytes", rx.size() - b_rx, NB);
        b_rx = rx.size();
        raw_pat = 8'hB2;
        for (int i = 7; i >= 0; i--) put_bit(raw_pat[i], 1'b0);
        repeat (3) cyc();
        chk("raw handshakes", rx.size() - b_rx, 1);
        chk("raw byte", rx[b_rx], 8'hB2);
        chk("raw overrun", overrun, 0);

        // Raw overrun with the UART stalled
        tx_ready = 1'b0;
        a_byte = 8'($urandom());
        b_byte = 8'($urandom());
        for (int i = 7; i >= 0; i--) put_bit(a_byte[i], 1'b0);
        for (int i = 7; i >= 0; i--) put_bit(b_byte[i], 1'b0);
        cyc();
        chk("overrun set", overrun, 1);
        chk("overrun held byte", tx_data, a_byte);
        chk("overrun held valid", tx_valid, 1);

        // Random soak
        for (int n = 0; n < 1500; n++) begin
            bit_valid = 1'($urandom_range(0, 1));
            bit_in    = 1'($urandom_range(0, 1));
            rct_fail  = ($urandom_range(0, 15) == 0);
            tx_ready  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) ctrl_mode = ~ctrl_mode;
            if ($urandom_range(0, 99) == 0) rand_digest();
            cyc();
        end
        bit_valid = 1'b0;
        rct_fail  = 1'b0;
        cyc();
        chk("overrun sticky", overrun, 1);

        // Reset mid-SEND drops tx_valid at once and discards the partial block
        rst = 1'b1;
        ctrl_mode = 1'b0;
        tx_ready = 1'b1;
        repeat (2) cyc();
        chk("overrun cleared", overrun, 0);
        rst = 1'b0;
        rand_digest();
        for (int i = 0; i < SB; i++) put_bit(1'($urandom_range(0, 1)), 1'b0);
        wait_phase(3, 100, "pre-reset send");
        repeat (3) cyc();
        #1 rst = 1'b1;
        #1;
        chk("async reset tx_valid", tx_valid, 0);
        chk("async reset hash_start", hash_start, 0);
        chk("async reset seed", seed, 0);
        repeat (2) cyc();
        rst = 1'b0;
        b_start = n_start;
        for (int i = 0; i < SB - 1; i++) put_bit(1'($urandom_range(0, 1)), 1'b0);
        repeat (3) cyc();
        chk("post-reset no early start", n_start - b_start, 0);
        put_bit(1'($urandom_range(0, 1)), 1'b0);
        wait_phase(0, 300, "post-reset send");
        chk("post-reset start", n_start - b_start, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
